// File: rtl/ap_ddr_dma_if.sv
// Bundle of every ap_ddr_dma signal except clock and reset.
//   cmd_*          : command channel from the AP control unit
//   busy/done      : engine status
//   rd_*/wr_*      : burst handshake and beat data to/from the DDR burst controller
//   buf_*          : on-chip buffer RAM ports (read data valid one cycle after buf_rd_en)
// Modports:
//   master : the DMA engine
//   slave  : its environment (control unit, controller and buffer RAM)
interface ap_ddr_dma_if #(
  parameter int unsigned DDR_DATA_WIDTH = 128,
  parameter int unsigned DDR_ADDR_WIDTH = 28,
  parameter int unsigned BUF_ADDR_WIDTH = 12
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_dir;
  logic [DDR_ADDR_WIDTH-1:0] cmd_ddr_addr;
  logic [BUF_ADDR_WIDTH-1:0] cmd_buf_addr;
  logic [15:0]               cmd_len;
  logic                      busy;
  logic                      done;

  logic                      rd_burst_req;
  logic [9:0]                rd_burst_len;
  logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr;
  logic                      rd_burst_data_valid;
  logic [DDR_DATA_WIDTH-1:0] rd_burst_data;
  logic                      rd_burst_finish;

  logic                      wr_burst_req;
  logic [9:0]                wr_burst_len;
  logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr;
  logic                      wr_burst_data_req;
  logic [DDR_DATA_WIDTH-1:0] wr_burst_data;
  logic                      wr_burst_finish;

  logic                      buf_wr_en;
  logic [BUF_ADDR_WIDTH-1:0] buf_wr_addr;
  logic [DDR_DATA_WIDTH-1:0] buf_wr_data;
  logic                      buf_rd_en;
  logic [BUF_ADDR_WIDTH-1:0] buf_rd_addr;
  logic [DDR_DATA_WIDTH-1:0] buf_rd_data;

  modport master (
    input  cmd_valid, cmd_dir, cmd_ddr_addr, cmd_buf_addr, cmd_len,
    output cmd_ready, busy, done,
    output rd_burst_req, rd_burst_len, rd_burst_addr,
    input  rd_burst_data_valid, rd_burst_data, rd_burst_finish,
    output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    input  wr_burst_data_req, wr_burst_finish,
    output buf_wr_en, buf_wr_addr, buf_wr_data, buf_rd_en, buf_rd_addr,
    input  buf_rd_data
  );

  modport slave (
    output cmd_valid, cmd_dir, cmd_ddr_addr, cmd_buf_addr, cmd_len,
    input  cmd_ready, busy, done,
    input  rd_burst_req, rd_burst_len, rd_burst_addr,
    output rd_burst_data_valid, rd_burst_data, rd_burst_finish,
    input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    output wr_burst_data_req, wr_burst_finish,
    input  buf_wr_en, buf_wr_addr, buf_wr_data, buf_rd_en, buf_rd_addr,
    output buf_rd_data
  );
endinterface

// File: rtl/ap_ddr_dma.sv
// Command-driven DMA engine sitting in front of the DDR burst controller.
// A load moves DDR -> buffer RAM, a store moves buffer RAM -> DDR. Each command of up to
// 65535 beats is split into bursts of at most MAX_BURST beats.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (aborts any command, no done pulse)
//   bus  : ap_ddr_dma_if.master carrying command, status, controller and buffer signals
module ap_ddr_dma #(
  parameter int unsigned DDR_DATA_WIDTH = 128,
  parameter int unsigned DDR_ADDR_WIDTH = 28,
  parameter int unsigned BUF_ADDR_WIDTH = 12,
  parameter int unsigned MAX_BURST      = 64,
  parameter int unsigned ADDR_STEP      = 8
) (
  input logic          clk,
  input logic          rst,
  ap_ddr_dma_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StNext,
    StRdReq,
    StRdWait,
    StWrReq,
    StWrWait,
    StDone
  } state_e;

  state_e                    state_q, state_d;
  logic                      dir_q;
  logic [DDR_ADDR_WIDTH-1:0] ddr_addr_q;
  logic [BUF_ADDR_WIDTH-1:0] buf_wr_addr_q;
  logic [BUF_ADDR_WIDTH-1:0] buf_rd_addr_q;
  logic [15:0]               remaining_q;
  logic [9:0]                blen_q;

  logic                      accept;
  logic                      rd_beat;
  logic                      wr_beat;
  logic                      burst_finish;
  logic [15:0]               remaining_after;
  logic [9:0]                blen_next;
  logic [DDR_ADDR_WIDTH-1:0] burst_bytes;
  logic [DDR_DATA_WIDTH-1:0] rd_beat_data;

  assign accept  = bus.cmd_valid && (state_q == StIdle);
  // Beats are only honoured while a burst of the matching direction is open.
  assign rd_beat = bus.rd_burst_data_valid && ((state_q == StRdReq) || (state_q == StRdWait));
  assign wr_beat = bus.wr_burst_data_req && ((state_q == StWrReq) || (state_q == StWrWait));
  // Finish pulses outside a WAIT state are ignored.
  assign burst_finish = ((state_q == StRdWait) && bus.rd_burst_finish) ||
                        ((state_q == StWrWait) && bus.wr_burst_finish);

  assign remaining_after = remaining_q - 16'(blen_q);
  // MAX_BURST <= 1023, so the narrowed length always fits in 10 bits.
  assign blen_next   = (remaining_q > 16'(MAX_BURST)) ? 10'(MAX_BURST) : remaining_q[9:0];
  assign burst_bytes = DDR_ADDR_WIDTH'(blen_q) * DDR_ADDR_WIDTH'(ADDR_STEP);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          state_d = (bus.cmd_len == 16'd0) ? StDone : StNext;
        end
      end
      StNext:   state_d = dir_q ? StWrReq : StRdReq;
      StRdReq:  if (bus.rd_burst_data_valid) state_d = StRdWait;
      StWrReq:  if (bus.wr_burst_data_req) state_d = StWrWait;
      StRdWait: begin
        if (bus.rd_burst_finish) state_d = (remaining_after == 16'd0) ? StDone : StNext;
      end
      StWrWait: begin
        if (bus.wr_burst_finish) state_d = (remaining_after == 16'd0) ? StDone : StNext;
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM-decoded outputs.
  always_comb begin
    bus.cmd_ready    = (state_q == StIdle);
    bus.busy         = (state_q != StIdle);
    bus.done         = (state_q == StDone);
    bus.rd_burst_req = (state_q == StRdReq);
    bus.wr_burst_req = (state_q == StWrReq);
    bus.buf_wr_en    = rd_beat;
    bus.buf_rd_en    = wr_beat;
  end

  // Command and burst bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q         <= 1'b0;
      ddr_addr_q    <= '0;
      buf_wr_addr_q <= '0;
      buf_rd_addr_q <= '0;
      remaining_q   <= '0;
      blen_q        <= '0;
    end else begin
      if (accept) begin
        dir_q         <= bus.cmd_dir;
        ddr_addr_q    <= bus.cmd_ddr_addr;
        buf_wr_addr_q <= bus.cmd_buf_addr;
        buf_rd_addr_q <= bus.cmd_buf_addr;
        remaining_q   <= bus.cmd_len;
      end
      if (state_q == StNext) begin
        blen_q <= blen_next;
      end
      // Buffer pointers run on across burst boundaries and wrap silently.
      if (rd_beat) begin
        buf_wr_addr_q <= buf_wr_addr_q + 1'b1;
      end
      if (wr_beat) begin
        buf_rd_addr_q <= buf_rd_addr_q + 1'b1;
      end
      if (burst_finish) begin
        ddr_addr_q  <= ddr_addr_q + burst_bytes;
        remaining_q <= remaining_after;
      end
    end
  end

  assign rd_beat_data      = bus.rd_burst_data;
  assign bus.buf_wr_data   = rd_beat_data;
  assign bus.buf_wr_addr   = buf_wr_addr_q;
  assign bus.buf_rd_addr   = buf_rd_addr_q;
  // Buffer read data lands one cycle after the request, matching the controller's
  // delayed write strobe, so it can be forwarded without a register.
  assign bus.wr_burst_data = bus.buf_rd_data;

  assign bus.rd_burst_len  = blen_q;
  assign bus.rd_burst_addr = ddr_addr_q;
  assign bus.wr_burst_len  = blen_q;
  assign bus.wr_burst_addr = ddr_addr_q;

endmodule

// File: tb/tb_ap_ddr_dma.sv
// Self-checking bench for ap_ddr_dma: behavioural DDR controller and buffer RAM models,
// expected bursts / buffer writes / write beats queued by the stimulus and popped by a
// negedge monitor.
module tb_ap_ddr_dma;
  localparam int unsigned DW   = 128;
  localparam int unsigned AW   = 28;
  localparam int unsigned BW   = 12;
  localparam int unsigned MAXB = 64;
  localparam int unsigned STEP = 8;

  typedef struct packed {
    logic          dir;
    logic [9:0]    len;
    logic [AW-1:0] addr;
  } burst_t;

  typedef struct packed {
    logic [BW-1:0] addr;
    logic [DW-1:0] data;
  } bufw_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int n_vec  = 0;
  int n_fail = 0;

  burst_t        exp_burst[$];
  bufw_t         exp_bufw[$];
  logic [DW-1:0] exp_wrd[$];

  int done_cnt    = 0;
  int burst_cnt   = 0;
  int beats_total = 0;
  int rd_fin_cyc  = 0;

  logic [DW-1:0] mem [0:(1<<BW)-1];
  logic          pre_en;
  logic [BW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  ap_ddr_dma_if #(.DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW), .BUF_ADDR_WIDTH(BW)) bus ();

  ap_ddr_dma #(
    .DDR_DATA_WIDTH(DW),
    .DDR_ADDR_WIDTH(AW),
    .BUF_ADDR_WIDTH(BW),
    .MAX_BURST     (MAXB),
    .ADDR_STEP     (STEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous buffer RAM, 1-cycle read latency, plus a preload port for the bench.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (bus.buf_wr_en) mem[bus.buf_wr_addr] <= bus.buf_wr_data;
    if (bus.buf_rd_en) bus.buf_rd_data <= mem[bus.buf_rd_addr];
  end

  function automatic logic [DW-1:0] rdat(input logic [AW-1:0] a);
    return {32'hD0D0_0000 ^ {4'h0, a}, {4'h0, a}, ~{4'h0, a}, 32'h0BAD_F00D};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_burst(input logic dir, input logic [9:0] len, input logic [AW-1:0] addr);
    burst_t e;
    if (exp_burst.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL burst_unexpected: got dir %0d len %0d addr %0h, none expected",
               dir, len, addr);
    end else begin
      e = exp_burst.pop_front();
      chk("burst_dir", 32'(dir), 32'(e.dir));
      chk("burst_len", 32'(len), 32'(e.len));
      chk("burst_addr", 32'(addr), 32'(e.addr));
    end
  endtask

  // Monitor: samples mid-cycle when inputs and combinational outputs are settled.
  initial begin
    logic  prev_rreq, prev_wreq, prev_dreq;
    bufw_t bw;
    prev_rreq = 1'b0;
    prev_wreq = 1'b0;
    prev_dreq = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rreq = 1'b0;
        prev_wreq = 1'b0;
        prev_dreq = 1'b0;
        continue;
      end
      if (bus.done) done_cnt++;
      if (bus.rd_burst_req && !prev_rreq) begin
        burst_cnt++;
        mon_burst(1'b0, bus.rd_burst_len, bus.rd_burst_addr);
      end
      if (bus.wr_burst_req && !prev_wreq) begin
        burst_cnt++;
        mon_burst(1'b1, bus.wr_burst_len, bus.wr_burst_addr);
      end
      if (bus.buf_wr_en) begin
        if (exp_bufw.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL bufw_unexpected: got addr %0h, none expected", bus.buf_wr_addr);
        end else begin
          bw = exp_bufw.pop_front();
          chk("bufw_addr", 32'(bus.buf_wr_addr), 32'(bw.addr));
          chkd("bufw_data", bus.buf_wr_data, bw.data);
        end
      end
      if (prev_dreq) begin
        if (exp_wrd.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL wr_data_unexpected: got %h, none expected", bus.wr_burst_data);
        end else begin
          chkd("wr_data", bus.wr_burst_data, exp_wrd.pop_front());
        end
      end
      prev_rreq = bus.rd_burst_req;
      prev_wreq = bus.wr_burst_req;
      prev_dreq = bus.wr_burst_data_req;
    end
  end

  // Controller model, read side: back-to-back beats, then a finish pulse.
  initial begin
    logic [9:0]    blen;
    logic [AW-1:0] baddr;
    logic          aborted;
    bus.rd_burst_data_valid = 1'b0;
    bus.rd_burst_data       = '0;
    bus.rd_burst_finish     = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst || !bus.rd_burst_req) continue;
      blen    = bus.rd_burst_len;
      baddr   = bus.rd_burst_addr;
      aborted = 1'b0;
      for (int i = 0; i < int'(blen); i++) begin
        bus.rd_burst_data_valid = 1'b1;
        bus.rd_burst_data       = rdat(baddr + AW'(i * STEP));
        @(posedge clk); #1;
        beats_total++;
        if (rst) begin
          aborted = 1'b1;
          break;
        end
      end
      bus.rd_burst_data_valid = 1'b0;
      if (aborted) continue;
      chk("rd_req_low_at_finish", 32'(bus.rd_burst_req), 0);
      bus.rd_burst_finish = 1'b1;
      rd_fin_cyc = cyc;
      @(posedge clk); #1;
      bus.rd_burst_finish = 1'b0;
    end
  end

  // Controller model, write side: data requests with random gaps, then a finish pulse.
  initial begin
    logic [9:0] blen;
    int         gap;
    bus.wr_burst_data_req = 1'b0;
    bus.wr_burst_finish   = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst || !bus.wr_burst_req) continue;
      blen = bus.wr_burst_len;
      for (int i = 0; i < int'(blen); i++) begin
        gap = int'($urandom_range(0, 2));
        repeat (gap) begin
          @(posedge clk); #1;
        end
        bus.wr_burst_data_req = 1'b1;
        @(posedge clk); #1;
        bus.wr_burst_data_req = 1'b0;
        if (i == 0) chk("wr_req_low_after_first_dreq", 32'(bus.wr_burst_req), 0);
      end
      @(posedge clk); #1;
      chk("wr_req_low_at_finish", 32'(bus.wr_burst_req), 0);
      bus.wr_burst_finish = 1'b1;
      @(posedge clk); #1;
      bus.wr_burst_finish = 1'b0;
    end
  end

  task automatic expect_load(input logic [AW-1:0] ddr, input logic [BW-1:0] ba, input int len);
    for (int k = 0; k < len; k++) begin
      exp_bufw.push_back('{addr: ba + BW'(k), data: rdat(ddr + AW'(k * STEP))});
    end
  endtask

  task automatic issue(input logic dir, input logic [AW-1:0] ddr, input logic [BW-1:0] ba,
                       input logic [15:0] len);
    for (int i = 0; i < 100 && !bus.cmd_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("cmd_ready_before_issue", 32'(bus.cmd_ready), 1);
    bus.cmd_valid    = 1'b1;
    bus.cmd_dir      = dir;
    bus.cmd_ddr_addr = ddr;
    bus.cmd_buf_addr = ba;
    bus.cmd_len      = len;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("busy_after_accept", 32'(bus.busy), 1);
    chk("cmd_ready_low_after_accept", 32'(bus.cmd_ready), 0);
  endtask

  task automatic wait_done(output int dcyc);
    int n;
    n = 0;
    while (!bus.done && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", 32'(bus.done), 1);
    dcyc = cyc;
    chk("cmd_ready_low_in_done", 32'(bus.cmd_ready), 0);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(bus.done), 0);
    chk("cmd_ready_after_done", 32'(bus.cmd_ready), 1);
    chk("busy_after_done", 32'(bus.busy), 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_rd_req"}, 32'(bus.rd_burst_req), 0);
    chk({tag, "_wr_req"}, 32'(bus.wr_burst_req), 0);
    chk({tag, "_buf_wr_en"}, 32'(bus.buf_wr_en), 0);
    chk({tag, "_buf_rd_en"}, 32'(bus.buf_rd_en), 0);
    chk({tag, "_rd_len"}, 32'(bus.rd_burst_len), 0);
    chk({tag, "_wr_len"}, 32'(bus.wr_burst_len), 0);
    chk({tag, "_rd_addr"}, 32'(bus.rd_burst_addr), 0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_burst_addr), 0);
    chk({tag, "_buf_wr_addr"}, 32'(bus.buf_wr_addr), 0);
    chk({tag, "_buf_rd_addr"}, 32'(bus.buf_rd_addr), 0);
  endtask

  // Watchdog so the bench always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w [3];
    int            dcyc, bc0, dc0, b0;
    logic          reached;
    w[0] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    w[1] = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1234;
    w[2] = 128'h0F0F_F0F0_1357_9BDF_2468_ACE0_DEAD_BEEF;

    bus.cmd_valid = 1'b0; bus.cmd_dir = 1'b0; bus.cmd_ddr_addr = '0;
    bus.cmd_buf_addr = '0; bus.cmd_len = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Load 4 beats from 0x100 into buffer words 0..3.
    bc0 = burst_cnt;
    exp_burst.push_back('{dir: 1'b0, len: 10'd4, addr: 28'h100});
    expect_load(28'h100, 12'h000, 4);
    issue(1'b0, 28'h100, 12'h000, 16'd4);
    wait_done(dcyc);
    chk("load4_done_after_finish", 32'(dcyc - rd_fin_cyc), 1);
    chk("load4_burst_count", 32'(burst_cnt - bc0), 1);
    for (int k = 0; k < 4; k++) chkd("load4_mem", mem[k], rdat(28'h100 + AW'(k * 8)));

    // Load 150 beats: 64 / 64 / 22.
    bc0 = burst_cnt;
    exp_burst.push_back('{dir: 1'b0, len: 10'd64, addr: 28'h2000});
    exp_burst.push_back('{dir: 1'b0, len: 10'd64, addr: 28'h2200});
    exp_burst.push_back('{dir: 1'b0, len: 10'd22, addr: 28'h2400});
    expect_load(28'h2000, 12'h000, 150);
    issue(1'b0, 28'h2000, 12'h000, 16'd150);
    wait_done(dcyc);
    chk("load150_burst_count", 32'(burst_cnt - bc0), 3);

    // Store 3 words from buffer 0x20.
    for (int k = 0; k < 3; k++) begin
      pre_en = 1'b1; pre_addr = 12'h020 + BW'(k); pre_data = w[k];
      @(posedge clk); #1;
    end
    pre_en = 1'b0;
    exp_burst.push_back('{dir: 1'b1, len: 10'd3, addr: 28'h3000});
    for (int k = 0; k < 3; k++) exp_wrd.push_back(w[k]);
    issue(1'b1, 28'h3000, 12'h020, 16'd3);
    wait_done(dcyc);

    // Length-1 load and length-1 store.
    bc0 = burst_cnt;
    exp_burst.push_back('{dir: 1'b0, len: 10'd1, addr: 28'h40});
    expect_load(28'h40, 12'h200, 1);
    issue(1'b0, 28'h40, 12'h200, 16'd1);
    wait_done(dcyc);
    chk("len1_load_burst_count", 32'(burst_cnt - bc0), 1);
    bc0 = burst_cnt;
    exp_burst.push_back('{dir: 1'b1, len: 10'd1, addr: 28'h50});
    exp_wrd.push_back(w[0]);
    issue(1'b1, 28'h50, 12'h020, 16'd1);
    wait_done(dcyc);
    chk("len1_store_burst_count", 32'(burst_cnt - bc0), 1);

    // Zero-length command: done only.
    bc0 = burst_cnt;
    issue(1'b0, 28'h777, 12'h055, 16'd0);
    wait_done(dcyc);
    chk("len0_no_burst", 32'(burst_cnt - bc0), 0);

    // Reset in the middle of the second burst of a 150-beat load.
    dc0 = done_cnt;
    b0  = beats_total;
    exp_burst.push_back('{dir: 1'b0, len: 10'd64, addr: 28'h8000});
    exp_burst.push_back('{dir: 1'b0, len: 10'd64, addr: 28'h8200});
    expect_load(28'h8000, 12'h300, 150);
    issue(1'b0, 28'h8000, 12'h300, 16'd150);
    reached = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (beats_total >= b0 + 74) begin
        reached = 1'b1;
        break;
      end
    end
    chk("abort_second_burst_reached", 32'(reached), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_burst.delete();
    exp_bufw.delete();
    exp_wrd.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - dc0), 0);
    exp_burst.push_back('{dir: 1'b0, len: 10'd2, addr: 28'h500});
    expect_load(28'h500, 12'h010, 2);
    issue(1'b0, 28'h500, 12'h010, 16'd2);
    wait_done(dcyc);

    repeat (5) @(posedge clk);
    #1;
    chk("total_done_pulses", 32'(done_cnt), 7);
    chk("burst_queue_drained", 32'(exp_burst.size()), 0);
    chk("bufw_queue_drained", 32'(exp_bufw.size()), 0);
    chk("wrd_queue_drained", 32'(exp_wrd.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
